// File: rtl/x25519_host.sv
// Byte-stream front end for the curve25519 ladder core: loads scalar and u, drives the core, streams
// the result. Optional all-zero result flag enabled by defining X25519_HOST_ZERO_CHECK_EN.
module x25519_host #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [7:0]   in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [7:0]   out_data_o,
  output logic         out_last_o,
  output logic         err_timeout_o,
  output logic         err_zero_o,
  output logic         busy_o,
  output logic         core_start_o,
  output logic [254:0] core_n_o,
  output logic [254:0] core_q_o,
  input  logic         core_done_i,
  input  logic [254:0] core_out_i
);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StSend} state_e;

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [511:0]   buf_q, buf_d;
  logic [254:0]   n_q, n_d;
  logic [254:0]   q_q, q_d;
  logic [255:0]   res_q, res_d;
  logic [31:0]    wait_cnt_q, wait_cnt_d;
  logic           err_timeout_q, err_timeout_d;
`ifdef X25519_HOST_ZERO_CHECK_EN
  logic           err_zero_q, err_zero_d;
`endif

  // Bits discarded by the clamp and the u mask.
  logic unused_bits;
  assign unused_bits = ^{buf_q[511], buf_q[255:254], buf_q[2:0], res_q[255:8]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    n_d           = n_q;
    q_d           = q_q;
    res_d         = res_q;
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
`ifdef X25519_HOST_ZERO_CHECK_EN
    err_zero_d    = err_zero_q;
`endif
    unique case (state_q)
      StLoad: begin
        if (in_valid_i) begin
          buf_d[{cnt_q, 3'b000} +: 8] = in_data_i;
          cnt_d         = cnt_q + 6'd1;
          err_timeout_d = 1'b0;
`ifdef X25519_HOST_ZERO_CHECK_EN
          err_zero_d    = 1'b0;
`endif
          if (cnt_q == 6'd63) state_d = StStart;
        end
      end
      StStart: begin
        n_d        = {1'b1, buf_q[253:3], 3'b000};
        q_d        = buf_q[510:256];
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 32'd1;
        // The first two WAIT cycles may still see done from the previous operation.
        if (wait_cnt_q >= 32'd2 && core_done_i) begin
          res_d   = {1'b0, core_out_i};
          state_d = StSend;
`ifdef X25519_HOST_ZERO_CHECK_EN
          err_zero_d = (core_out_i == '0);
`endif
        end else if (TIMEOUT_CYCLES != 0 && wait_cnt_d == TIMEOUT_CYCLES) begin
          err_timeout_d = 1'b1;
          state_d       = StLoad;
        end
      end
      StSend: begin
        if (out_ready_i) begin
          res_d = {8'h00, res_q[255:8]};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            cnt_d   = '0;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StLoad;
      cnt_q         <= '0;
      buf_q         <= '0;
      n_q           <= '0;
      q_q           <= '0;
      res_q         <= '0;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
`ifdef X25519_HOST_ZERO_CHECK_EN
      err_zero_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      n_q           <= n_d;
      q_q           <= q_d;
      res_q         <= res_d;
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
`ifdef X25519_HOST_ZERO_CHECK_EN
      err_zero_q    <= err_zero_d;
`endif
    end
  end

  assign in_ready_o    = (state_q == StLoad);
  assign busy_o        = (state_q != StLoad);
  assign core_start_o  = (state_q == StStart);
  assign out_valid_o   = (state_q == StSend);
  assign out_last_o    = (state_q == StSend) && (cnt_q == 6'd31);
  assign out_data_o    = res_q[7:0];
  assign core_n_o      = n_q;
  assign core_q_o      = q_q;
  assign err_timeout_o = err_timeout_q;
`ifdef X25519_HOST_ZERO_CHECK_EN
  assign err_zero_o    = err_zero_q;
`else
  assign err_zero_o    = 1'b0;
`endif

endmodule
